// File: rtl/cnn_pkg.sv
// Shared CNN constants and the pool reader state type.
package cnn_pkg;

  localparam int NUM_CH          = 8;
  localparam int POOL_X          = 12;
  localparam int POOL_Y          = 12;
  localparam int RELU_DATA_WIDTH = 45;
  localparam int TOTAL           = NUM_CH * POOL_X * POOL_Y;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } pool_rd_state_t;

endpackage

// File: rtl/pool_elem_mux.sv
// Selects one element from the flattened snapshot and decodes its channel.
module pool_elem_mux #(
  parameter int NUM_CH     = cnn_pkg::NUM_CH,
  parameter int POOL_X     = cnn_pkg::POOL_X,
  parameter int POOL_Y     = cnn_pkg::POOL_Y,
  parameter int DATA_WIDTH = cnn_pkg::RELU_DATA_WIDTH
) (
  input  logic [NUM_CH*POOL_X*POOL_Y*DATA_WIDTH-1:0] snap,
  input  logic [$clog2(NUM_CH*POOL_X*POOL_Y)-1:0]    sel,
  output logic [DATA_WIDTH-1:0]                      elem,
  output logic [$clog2(NUM_CH)-1:0]                  ch
);

  localparam int MAP   = POOL_X * POOL_Y;
  localparam int IDX_W = $clog2(NUM_CH * POOL_X * POOL_Y);
  localparam int CH_W  = $clog2(NUM_CH);

  // Flat index already follows channel, x, y order, so a plain part-select suffices.
  assign elem = snap[sel*DATA_WIDTH +: DATA_WIDTH];
  assign ch   = CH_W'(sel / IDX_W'(MAP));

endmodule

// File: rtl/pool_stream_reader.sv
// Snapshots the pooled maps on each pool_done rise and streams them out
// one element per beat over a valid/ready handshake.
module pool_stream_reader #(
  parameter int NUM_CH     = cnn_pkg::NUM_CH,
  parameter int POOL_X     = cnn_pkg::POOL_X,
  parameter int POOL_Y     = cnn_pkg::POOL_Y,
  parameter int DATA_WIDTH = cnn_pkg::RELU_DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       pool_done,
  input  logic [NUM_CH*POOL_X*POOL_Y*DATA_WIDTH-1:0] pool_data,
  output logic [DATA_WIDTH-1:0]                      fc_data,
  output logic                                       fc_valid,
  input  logic                                       fc_ready,
  output logic                                       fc_last,
  output logic [$clog2(NUM_CH)-1:0]                  fc_ch,
  output logic                                       busy,
  output logic                                       stream_done,
  output logic                                       overrun
);

  import cnn_pkg::*;

  localparam int TOTAL_L = NUM_CH * POOL_X * POOL_Y;
  localparam int IDX_W   = $clog2(TOTAL_L);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_L - 1);

  pool_rd_state_t                  state;
  logic [IDX_W-1:0]                idx;
  logic                            pool_done_q;
  logic                            rise;
  logic [TOTAL_L*DATA_WIDTH-1:0]   snap;
  logic [IDX_W-1:0]                sel;
  logic [DATA_WIDTH-1:0]           mux_data;
  logic [CH_W-1:0]                 mux_ch;
  logic                            beat;

  assign rise        = pool_done & ~pool_done_q;
  assign beat        = fc_valid & fc_ready;
  assign busy        = (state != IDLE);
  assign stream_done = (state == DONE);

  // LOAD presents element 0 (idx is 0 there); STREAM pre-fetches the next element.
  assign sel = (state == STREAM && idx != LAST_IDX) ? idx + 1'b1 : idx;

  pool_elem_mux #(
    .NUM_CH     (NUM_CH),
    .POOL_X     (POOL_X),
    .POOL_Y     (POOL_Y),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mux (
    .snap (snap),
    .sel  (sel),
    .elem (mux_data),
    .ch   (mux_ch)
  );

  // Snapshot capture: only an accepted frame start overwrites the stored maps.
  always_ff @(posedge clk) begin
    if (state == IDLE && rise)
      snap <= pool_data;
  end

  // Frame FSM, edge detector, element index and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      pool_done_q <= 1'b0;
      fc_valid    <= 1'b0;
      fc_last     <= 1'b0;
      fc_ch       <= '0;
      fc_data     <= '0;
      overrun     <= 1'b0;
    end else begin
      pool_done_q <= pool_done;
      if (rise && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rise)
            state <= LOAD;
        end
        LOAD: begin
          fc_data  <= mux_data;
          fc_ch    <= mux_ch;
          fc_valid <= 1'b1;
          fc_last  <= (TOTAL_L == 1);
          state    <= STREAM;
        end
        STREAM: begin
          if (beat) begin
            if (idx == LAST_IDX) begin
              fc_valid <= 1'b0;
              fc_last  <= 1'b0;
              state    <= DONE;
            end else begin
              idx     <= idx + 1'b1;
              fc_data <= mux_data;
              fc_ch   <= mux_ch;
              fc_last <= ((idx + 1'b1) == LAST_IDX);
            end
          end
        end
        DONE: begin
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_stream_reader.sv
// Bench for pool_stream_reader: scenario table plus hand-written reset sequences,
// checked against a per-(c,x,y) frame model.
module tb_pool_stream_reader;
  import cnn_pkg::*;

  localparam int DW  = RELU_DATA_WIDTH;
  localparam int MAP = POOL_X * POOL_Y;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       pool_done;
  logic [TOTAL*DW-1:0]        pool_data;
  logic [DW-1:0]              fc_data;
  logic                       fc_valid;
  logic                       fc_ready;
  logic                       fc_last;
  logic [$clog2(NUM_CH)-1:0]  fc_ch;
  logic                       busy;
  logic                       stream_done;
  logic                       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fm [NUM_CH][POOL_X][POOL_Y];

  typedef struct {
    int duty;       // fc_ready probability in percent
    bit new_rise;   // drive a fresh 0->1 on pool_done
    bit snap_kill;  // drop pool_done and zero pool_data right after capture
    int ovr_beat;   // beat at which a second rise is injected, -1 for none
    bit rnd;        // random frame contents instead of the counting pattern
    bit exp_ovr;    // overrun value expected after the frame
  } scen_t;

  scen_t tbl[5];

  pool_stream_reader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pool_done   (pool_done),
    .pool_data   (pool_data),
    .fc_data     (fc_data),
    .fc_valid    (fc_valid),
    .fc_ready    (fc_ready),
    .fc_last     (fc_last),
    .fc_ch       (fc_ch),
    .busy        (busy),
    .stream_done (stream_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fill_pattern();
    for (int c = 0; c < NUM_CH; c++)
      for (int x = 0; x < POOL_X; x++)
        for (int y = 0; y < POOL_Y; y++)
          fm[c][x][y] = DW'(c*1000 + x*12 + y);
  endfunction

  function automatic void fill_random();
    for (int c = 0; c < NUM_CH; c++)
      for (int x = 0; x < POOL_X; x++)
        for (int y = 0; y < POOL_Y; y++)
          fm[c][x][y] = DW'({$urandom, $urandom});
  endfunction

  function automatic logic [TOTAL*DW-1:0] pack();
    logic [TOTAL*DW-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int x = 0; x < POOL_X; x++)
        for (int y = 0; y < POOL_Y; y++)
          v[((c*POOL_X + x)*POOL_Y + y)*DW +: DW] = fm[c][x][y];
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int k);
    return fm[k / MAP][(k / POOL_Y) % POOL_X][k % POOL_Y];
  endfunction

  // Runs one frame and checks contents, handshake stability, done pulse and overrun.
  task automatic run_frame(input scen_t s);
    int k = 0, cyc = 0, bad = 0, stall_bad = 0, sd_early = 0, first_valid = -1;
    bit last_acc = 0, prev_stall = 0, ovr_low = 0, ovr_hit = 0, ready, sd_right;
    logic [DW-1:0] pd;
    logic [$clog2(NUM_CH)-1:0] pch;
    logic pl;
    sd_right = 0;
    pd = '0; pch = '0; pl = 1'b0;
    if (s.new_rise) begin
      pool_done = 1'b0;
      fc_ready  = 1'b0;
      tick();
      pool_data = pack();
      pool_done = 1'b1;
    end
    tick();
    if (s.snap_kill) begin
      pool_done = 1'b0;
      pool_data = '0;
    end
    while (cyc < 8000) begin
      if (last_acc) begin
        sd_right = stream_done;
        fc_ready = 1'b0;
        tick();
        break;
      end
      if (stream_done) sd_early++;
      if (fc_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!fc_valid || fc_data !== pd || fc_ch !== pch || fc_last !== pl))
        stall_bad++;
      if (fc_valid) begin
        if (fc_data !== exp_data(k) || fc_ch !== ($clog2(NUM_CH))'(k / MAP) ||
            fc_last !== (k == TOTAL-1)) begin
          if (bad == 0)
            $display("first bad beat %0d: data %0h ch %0d last %0b", k, fc_data, fc_ch, fc_last);
          bad++;
        end
      end
      if (s.ovr_beat >= 0) begin
        if (!ovr_low && k >= s.ovr_beat - 1) begin
          pool_done = 1'b0;
          pool_data = ~pack();
          ovr_low   = 1;
        end else if (ovr_low && !ovr_hit && k >= s.ovr_beat) begin
          pool_done = 1'b1;
          ovr_hit   = 1;
        end
      end
      ready      = ($urandom_range(0, 99) < s.duty);
      fc_ready   = ready;
      prev_stall = fc_valid && !ready;
      pd = fc_data; pch = fc_ch; pl = fc_last;
      last_acc   = fc_valid && ready && (k == TOTAL-1);
      if (fc_valid && ready) k++;
      tick();
      cyc++;
    end
    check("first_valid_latency", 64'(first_valid), 64'd1);
    check("beat_count", 64'(k), 64'(TOTAL));
    check("beat_contents_bad", 64'(bad), 64'd0);
    check("stall_stability_bad", 64'(stall_bad), 64'd0);
    check("stream_done_early", 64'(sd_early), 64'd0);
    check("stream_done_after_last", 64'(sd_right), 64'd1);
    check("stream_done_single", 64'(stream_done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
    check("valid_after_done", 64'(fc_valid), 64'd0);
    check("overrun_after_frame", 64'(overrun), 64'(s.exp_ovr));
  endtask

  initial begin
    int busy_cnt, sd_cnt, k, bad;
    tbl[0] = '{duty: 100, new_rise: 1, snap_kill: 0, ovr_beat: -1,  rnd: 0, exp_ovr: 0};
    tbl[1] = '{duty: 30,  new_rise: 1, snap_kill: 0, ovr_beat: -1,  rnd: 0, exp_ovr: 0};
    tbl[2] = '{duty: 100, new_rise: 1, snap_kill: 1, ovr_beat: -1,  rnd: 0, exp_ovr: 0};
    tbl[3] = '{duty: 100, new_rise: 1, snap_kill: 0, ovr_beat: 300, rnd: 0, exp_ovr: 1};
    tbl[4] = '{duty: 60,  new_rise: 1, snap_kill: 0, ovr_beat: -1,  rnd: 1, exp_ovr: 1};

    // Reset with pool_done held high.
    fill_pattern();
    rst_n     = 1'b0;
    pool_done = 1'b1;
    pool_data = pack();
    fc_ready  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("rst_fc_valid", 64'(fc_valid), 64'd0);
    check("rst_fc_data", 64'(fc_data), 64'd0);
    check("rst_fc_last", 64'(fc_last), 64'd0);
    check("rst_fc_ch", 64'(fc_ch), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stream_done", 64'(stream_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    run_frame('{duty: 100, new_rise: 0, snap_kill: 0, ovr_beat: -1, rnd: 0, exp_ovr: 0});
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || fc_valid) busy_cnt++;
      tick();
    end
    check("held_high_single_frame", 64'(busy_cnt), 64'd0);

    // Scenario table.
    for (int t = 0; t < 5; t++) begin
      if (tbl[t].rnd) fill_random(); else fill_pattern();
      run_frame(tbl[t]);
    end

    // Mid-frame reset at beat 500.
    fill_pattern();
    pool_done = 1'b0;
    fc_ready  = 1'b1;
    tick();
    pool_data = pack();
    pool_done = 1'b1;
    tick();
    k = 0; bad = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (fc_valid) begin
        if (fc_data !== exp_data(k)) bad++;
        if (k == 500) break;
        k++;
      end
      tick();
    end
    check("midrst_reached_beat", 64'(k), 64'd500);
    check("midrst_contents_bad", 64'(bad), 64'd0);
    rst_n = 1'b0;
    tick();
    check("midrst_fc_valid", 64'(fc_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_overrun_cleared", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    pool_done = 1'b0;
    sd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (stream_done || fc_valid) sd_cnt++;
      tick();
    end
    check("midrst_no_done", 64'(sd_cnt), 64'd0);
    fill_random();
    run_frame('{duty: 100, new_rise: 1, snap_kill: 0, ovr_beat: -1, rnd: 1, exp_ovr: 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
